// File: rtl/lamp_sequencer_if.sv
// Lamp sequencer bus: target/load/step_div requests in, lamp state out.
// Latency: none, wires only; no backpressure, the master may load at any cycle.
interface lamp_sequencer_if #(
  parameter int TICK_W = 8
);
  logic [3:0]        target;
  logic              load;
  logic [TICK_W-1:0] step_div;
  logic [14:0]       lamp_en;
  logic [3:0]        count;
  logic              busy;
  logic              done;

  modport master (
    output target, load, step_div,
    input  lamp_en, count, busy, done
  );

  modport slave (
    input  target, load, step_div,
    output lamp_en, count, busy, done
  );
endinterface

// File: rtl/lamp_sequencer.sv
// Ramps a thermometer lamp bar toward a loaded target, one lamp per step.
// Latency: first step step_div+1 edges after load; no backpressure, every load is accepted.
module lamp_sequencer #(
  parameter int TICK_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  lamp_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [3:0]        target_q, target_d;
  logic [TICK_W-1:0] timer_q, timer_d;
  logic              done_q, done_d;
  logic [14:0]       lamp_en_q, lamp_en_d;
  logic [3:0]        eff_target;
  logic [3:0]        stepped;

  function automatic logic [14:0] therm(input logic [3:0] n);
    logic [14:0] v;
    v = '0;
    for (int i = 0; i < 15; i++) begin
      v[i] = (i < int'(n));
    end
    return v;
  endfunction

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    target_d   = target_q;
    timer_d    = timer_q;
    done_d     = 1'b0;
    stepped    = count_q;
    eff_target = bus.load ? bus.target : target_q;

    if (bus.load) begin
      target_d = bus.target;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (bus.target == count_q) begin
            done_d = 1'b1;
          end else begin
            state_d = (bus.target > count_q) ? UP : DOWN;
            timer_d = bus.step_div;
          end
        end
      end
      UP, DOWN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TICK_W'(1);
        end else begin
          // Step direction uses the target held before this edge; a load on this
          // same edge is only compared against the post-step count.
          if (target_q > count_q && count_q != 4'd15) begin
            stepped = count_q + 4'd1;
          end else if (target_q < count_q && count_q != 4'd0) begin
            stepped = count_q - 4'd1;
          end
          count_d = stepped;
          timer_d = bus.step_div;
          if (eff_target == stepped) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = (eff_target > stepped) ? UP : DOWN;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    lamp_en_d = therm(count_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      target_q  <= '0;
      timer_q   <= '0;
      done_q    <= 1'b0;
      lamp_en_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      target_q  <= target_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      lamp_en_q <= lamp_en_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.lamp_en = lamp_en_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed and randomised checks of lamp_sequencer ramps, reloads and reset.
// Outputs are sampled 1 time unit after the rising edge; invariants on the falling edge.
module tb_lamp_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_seen = 0;
  int   d0;
  int   snap;
  logic [3:0] prev_count;
  logic       prev_vld = 1'b0;

  always #5 clk = ~clk;

  lamp_sequencer_if #(.TICK_W(8)) bus ();

  lamp_sequencer #(.TICK_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [14:0] therm(input logic [3:0] n);
    logic [15:0] m;
    m = (16'd1 << n) - 16'd1;
    return m[14:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.busy), 32'd0);
    tick();
  endtask

  task automatic ramp_to(input logic [3:0] t);
    bus.step_div = 8'd0;
    bus.target   = t;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
    wait_idle("ramp_to_idle");
    check("ramp_to_count", 32'(bus.count), 32'(t));
  endtask

  // Per-cycle invariants and done-pulse counting.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_vld = 1'b0;
    end else begin
      int d;
      check("lamp_therm", 32'(bus.lamp_en), 32'(therm(bus.count)));
      if (prev_vld) begin
        d = int'(bus.count) - int'(prev_count);
        check("step_delta", 32'(d >= -1 && d <= 1), 32'd1);
      end
      if (bus.done === 1'b1) done_seen++;
      prev_count = bus.count;
      prev_vld   = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    bus.target   = 4'd0;
    bus.load     = 1'b0;
    bus.step_div = 8'd0;
    #12;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_lamp",  32'(bus.lamp_en), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp 0 -> 5 at one step per cycle
    d0 = done_seen;
    bus.step_div = 8'd0;
    bus.target   = 4'd5;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    check("up5_busy0", 32'(bus.busy), 32'd1);
    check("up5_cnt0",  32'(bus.count), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("up5_count", 32'(bus.count), 32'(k));
      check("up5_lamp",  32'(bus.lamp_en), 32'(therm(4'(k))));
      check("up5_busy",  32'(bus.busy), 32'(k < 5));
      check("up5_done",  32'(bus.done), 32'(k == 5));
    end
    tick();
    check("up5_done_clr", 32'(bus.done), 32'd0);
    check("up5_lamp_end", 32'(bus.lamp_en), 32'h001F);
    check("up5_done_cnt", 32'(done_seen - d0), 32'd1);

    // Ramp 5 -> 2 with step_div=3
    d0 = done_seen;
    bus.step_div = 8'd3;
    bus.target   = 4'd2;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      check("dn2_count", 32'(bus.count), 32'(5 - j / 4));
      check("dn2_busy",  32'(bus.busy), 32'(j < 12));
      check("dn2_done",  32'(bus.done), 32'(j == 12));
    end
    tick();
    check("dn2_lamp_end", 32'(bus.lamp_en), 32'h0003);
    check("dn2_done_cnt", 32'(done_seen - d0), 32'd1);

    // No-op load at count 7
    ramp_to(4'd7);
    d0 = done_seen;
    bus.target = 4'd7;
    bus.load   = 1'b1;
    tick();
    bus.load = 1'b0;
    check("noop_busy",  32'(bus.busy), 32'd0);
    check("noop_done",  32'(bus.done), 32'd1);
    check("noop_count", 32'(bus.count), 32'd7);
    tick();
    check("noop_busy2",  32'(bus.busy), 32'd0);
    check("noop_done2",  32'(bus.done), 32'd0);
    check("noop_count2", 32'(bus.count), 32'd7);
    check("noop_done_cnt", 32'(done_seen - d0), 32'd1);

    // Ramp 0 -> 12 reversed to 2 at count 4
    ramp_to(4'd0);
    d0 = done_seen;
    bus.step_div = 8'd1;
    bus.target   = 4'd12;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      check("rev_up_count", 32'(bus.count), 32'(j / 2));
    end
    bus.target = 4'd2;
    bus.load   = 1'b1;
    tick();
    bus.load = 1'b0;
    check("rev_hold_count", 32'(bus.count), 32'd4);
    check("rev_hold_busy",  32'(bus.busy), 32'd1);
    tick();
    check("rev_step1", 32'(bus.count), 32'd3);
    check("rev_step1_done", 32'(bus.done), 32'd0);
    tick();
    check("rev_wait", 32'(bus.count), 32'd3);
    tick();
    check("rev_step2", 32'(bus.count), 32'd2);
    check("rev_done",  32'(bus.done), 32'd1);
    check("rev_busy",  32'(bus.busy), 32'd0);
    tick();
    check("rev_done_clr", 32'(bus.done), 32'd0);
    check("rev_done_cnt", 32'(done_seen - d0), 32'd1);

    // Asynchronous reset mid-ramp
    ramp_to(4'd0);
    bus.step_div = 8'd0;
    bus.target   = 4'd15;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (9) tick();
    check("ar_pre_count", 32'(bus.count), 32'd9);
    snap = done_seen;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count", 32'(bus.count), 32'd0);
    check("ar_lamp",  32'(bus.lamp_en), 32'd0);
    check("ar_busy",  32'(bus.busy), 32'd0);
    check("ar_done",  32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    bus.target = 4'd1;
    bus.load   = 1'b1;
    tick();
    bus.load = 1'b0;
    check("ar_first_busy", 32'(bus.busy), 32'd1);
    check("ar_no_done", 32'(done_seen - snap), 32'd0);
    tick();
    check("ar_first_count", 32'(bus.count), 32'd1);
    check("ar_first_done",  32'(bus.done), 32'd1);
    tick();

    // Random loads, some reloaded while busy
    for (int it = 0; it < 20; it++) begin
      logic [3:0] t;
      t  = 4'($urandom_range(0, 15));
      d0 = done_seen;
      bus.step_div = 8'($urandom_range(0, 3));
      bus.target   = t;
      bus.load     = 1'b1;
      tick();
      bus.load = 1'b0;
      if (bus.busy === 1'b1 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 5)) tick();
        if (bus.busy === 1'b1) begin
          t = 4'($urandom_range(0, 15));
          bus.step_div = 8'($urandom_range(0, 3));
          bus.target   = t;
          bus.load     = 1'b1;
          tick();
          bus.load = 1'b0;
        end
      end
      wait_idle("rand_idle");
      check("rand_count", 32'(bus.count), 32'(t));
      check("rand_done_cnt", 32'(done_seen - d0), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
